// File: rtl/bmain_pkg.sv
// bmain_pkg: shared types for the main-bus arbiter.
// Channel bundles, burst length and arbiter state encoding.
package bmain_pkg;

    localparam int BMAIN_BURST_LEN = 4;

    typedef struct packed {
        logic        valid;
        logic        cmd;
        logic [27:2] addr;
    } bmain_c_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic [3:0]  mask;
    } bmain_w_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [31:0] data;
    } bmain_r_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA
    } bmain_state_e;

endpackage

// File: rtl/bmain_arb.sv
// bmain_arb: two-master burst arbiter in front of the DRAM controller.
// Master 0 = icache refill, master 1 = dcache refill/writeback.
module bmain_arb
    import bmain_pkg::*;
#(
    parameter int BURST_LEN = BMAIN_BURST_LEN
) (
    input  logic              clk_core,
    input  logic              reset_n,
    input  bmain_c_t [1:0]    m_c,
    output logic [1:0]        m_cready,
    input  bmain_w_t [1:0]    m_w,
    output logic [1:0]        m_wready,
    output bmain_r_t [1:0]    m_r,
    input  logic [1:0]        m_rready,
    output logic              bmain_cvalid_dctl,
    input  logic              dctl_cready,
    output logic              bmain_cmd,
    output logic [27:2]       bmain_addr,
    output logic              bmain_wvalid_dctl,
    input  logic              dctl_wready,
    output logic              bmain_wlast,
    output logic [31:0]       bmain_wdata,
    output logic [3:0]        bmain_wmask,
    input  logic              dctl_rvalid,
    output logic              bmain_rready_dctl,
    input  logic              dctl_rlast,
    input  logic [31:0]       dctl_rdata,
    output logic              arb_error
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    bmain_state_e  r_state;
    bmain_state_e  w_state_nxt;
    logic          r_owner;
    logic          w_owner_nxt;
    logic          r_ptr;
    logic          w_ptr_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          w_pick;
    logic          w_beat;
    logic          w_last;

    assign arb_error = r_err;

    // Round-robin pick: pointer master wins a tie, else the lone requester.
    always_comb begin
        w_pick = 1'b0;
        unique case (1'b1)
            (m_c[0].valid & m_c[1].valid):  w_pick = r_ptr;
            (m_c[1].valid & ~m_c[0].valid): w_pick = 1'b1;
            default:                        w_pick = 1'b0;
        endcase
    end

    // State, ownership, beat counter and sticky error registers.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next state: grant in IDLE, command beat, then data beats until last.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (m_c[0].valid | m_c[1].valid) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (m_c[r_owner].valid & dctl_cready) begin
                    w_state_nxt = m_c[r_owner].cmd ? ST_RDATA : ST_WDATA;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WDATA: begin
                w_beat = m_w[r_owner].valid & dctl_wready;
                w_last = m_w[r_owner].last;
            end
            ST_RDATA: begin
                w_beat = dctl_rvalid & m_rready[r_owner];
                w_last = dctl_rlast;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A last flag must coincide exactly with the final counted beat.
        if (w_beat) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_last != (r_cnt == LAST_CNT)) begin
                w_err_nxt = 1'b1;
            end
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = ~r_owner;
            end
        end
    end

    // Channel muxing: only the owner sees ready/valid, read data fans out.
    always_comb begin
        bmain_cvalid_dctl = 1'b0;
        bmain_cmd         = m_c[r_owner].cmd;
        bmain_addr        = m_c[r_owner].addr;
        bmain_wvalid_dctl = 1'b0;
        bmain_wlast       = m_w[r_owner].last;
        bmain_wdata       = m_w[r_owner].data;
        bmain_wmask       = m_w[r_owner].mask;
        bmain_rready_dctl = 1'b0;
        m_cready          = 2'b00;
        m_wready          = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_r[i].valid = 1'b0;
            m_r[i].last  = dctl_rlast;
            m_r[i].data  = dctl_rdata;
        end
        unique case (r_state)
            ST_IDLE: begin
            end
            ST_CMD: begin
                bmain_cvalid_dctl = m_c[r_owner].valid;
                m_cready[r_owner] = dctl_cready;
            end
            ST_WDATA: begin
                bmain_wvalid_dctl = m_w[r_owner].valid;
                m_wready[r_owner] = dctl_wready;
            end
            ST_RDATA: begin
                bmain_rready_dctl  = m_rready[r_owner];
                m_r[r_owner].valid = dctl_rvalid;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bmain_arb.sv
// tb_bmain_arb: randomized bench for bmain_arb.
// Transaction-level model predicts grant order, data and error flag.
module tb_bmain_arb;
    import bmain_pkg::*;

    localparam int BL  = BMAIN_BURST_LEN;
    localparam int LIM = 3000;

    typedef struct packed {
        logic        m;
        logic        rd;
        logic [27:2] addr;
        logic [31:0] base;
        logic [3:0]  mask;
        logic [3:0]  lp;
    } txn_t;

    logic           clk_core;
    logic           reset_n;
    bmain_c_t [1:0] m_c;
    logic [1:0]     m_cready;
    bmain_w_t [1:0] m_w;
    logic [1:0]     m_wready;
    bmain_r_t [1:0] m_r;
    logic [1:0]     m_rready;
    logic           bmain_cvalid_dctl;
    logic           dctl_cready;
    logic           bmain_cmd;
    logic [27:2]    bmain_addr;
    logic           bmain_wvalid_dctl;
    logic           dctl_wready;
    logic           bmain_wlast;
    logic [31:0]    bmain_wdata;
    logic [3:0]     bmain_wmask;
    logic           dctl_rvalid;
    logic           bmain_rready_dctl;
    logic           dctl_rlast;
    logic [31:0]    dctl_rdata;
    logic           arb_error;

    bmain_arb #(.BURST_LEN(BL)) dut (
        .clk_core          (clk_core),
        .reset_n           (reset_n),
        .m_c               (m_c),
        .m_cready          (m_cready),
        .m_w               (m_w),
        .m_wready          (m_wready),
        .m_r               (m_r),
        .m_rready          (m_rready),
        .bmain_cvalid_dctl (bmain_cvalid_dctl),
        .dctl_cready       (dctl_cready),
        .bmain_cmd         (bmain_cmd),
        .bmain_addr        (bmain_addr),
        .bmain_wvalid_dctl (bmain_wvalid_dctl),
        .dctl_wready       (dctl_wready),
        .bmain_wlast       (bmain_wlast),
        .bmain_wdata       (bmain_wdata),
        .bmain_wmask       (bmain_wmask),
        .dctl_rvalid       (dctl_rvalid),
        .bmain_rready_dctl (bmain_rready_dctl),
        .dctl_rlast        (dctl_rlast),
        .dctl_rdata        (dctl_rdata),
        .arb_error         (arb_error)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    int   n_chk, n_fail;
    txn_t mtx [2][32];
    int   mhead [2];
    int   mcnt [2];
    bit   cmd_done [2];
    int   widx [2];
    int   ridx [2];
    txn_t ord [64];
    int   ocnt, kc, dph, dw, dr;
    int   cyc, last_end, rbeats, bp_cnt;
    bit   mptr, err_exp, bp_mode;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rpat(input logic [27:2] a, input int b);
        return {a[17:2], 14'h0, 2'(b)} ^ 32'hA5A5_0000;
    endfunction

    task automatic add(input bit m, input bit rd, input logic [27:2] a,
                       input logic [31:0] base, input logic [3:0] mask,
                       input int lp);
        txn_t t;
        t.m = m; t.rd = rd; t.addr = a;
        t.base = base; t.mask = mask; t.lp = 4'(lp);
        mtx[m][mcnt[m]] = t;
        mcnt[m]++;
        if (!rd && lp != BL - 1) err_exp = 1'b1;
    endtask

    task automatic clear_masters();
        for (int i = 0; i < 2; i++) begin
            mhead[i] = 0; mcnt[i] = 0;
            cmd_done[i] = 1'b0; widx[i] = 0; ridx[i] = 0;
        end
    endtask

    task automatic drive_idle();
        m_c = '0; m_w = '0; m_rready = 2'b00;
        dctl_cready = 1'b0; dctl_wready = 1'b0;
        dctl_rvalid = 1'b0; dctl_rlast = 1'b0; dctl_rdata = '0;
    endtask

    task automatic drive();
        txn_t t;
        for (int i = 0; i < 2; i++) begin
            m_c[i] = '0;
            m_w[i] = '0;
            m_rready[i] = ($urandom % 4) != 0;
            if (mhead[i] < mcnt[i]) begin
                t = mtx[i][mhead[i]];
                m_c[i].valid = !cmd_done[i];
                m_c[i].cmd   = t.rd;
                m_c[i].addr  = t.addr;
                if (!t.rd && widx[i] <= int'(t.lp)) begin
                    m_w[i].valid = ($urandom % 4) != 0;
                    m_w[i].last  = (widx[i] == int'(t.lp));
                    m_w[i].data  = t.base + 32'(widx[i]);
                    m_w[i].mask  = t.mask;
                end
            end
        end
        if (bp_mode && dph == 1 && dr >= 2 && bp_cnt < 3) begin
            m_rready = 2'b00;
            bp_cnt++;
        end
        dctl_cready = ($urandom % 4) != 0;
        dctl_wready = ($urandom % 4) != 0;
        dctl_rvalid = (dph == 1) && (bp_mode || ($urandom % 4) != 0);
        dctl_rlast  = (dph == 1) && (dr == BL - 1);
        dctl_rdata  = (dph == 1) ? rpat(ord[kc-1].addr, dr) : $urandom;
    endtask

    task automatic observe();
        txn_t t;
        bit   dm;
        dm = (kc > 0) ? ord[kc-1].m : 1'b0;
        if (dph != 0) chk("cmd_in_data", {bmain_cvalid_dctl, m_cready}, 0);
        for (int j = 0; j < 2; j++) begin
            if (!(dph == 2 && j == int'(dm)))
                chk("wready_gate", m_wready[j], 0);
            if (!(dph == 1 && j == int'(dm)))
                chk("rvalid_gate", m_r[j].valid, 0);
            if (dph == 0 && (kc >= ocnt || j != int'(ord[kc].m)))
                chk("cready_gate", m_cready[j], 0);
        end
        if (dph != 2) chk("wvalid_gate", bmain_wvalid_dctl, 0);
        if (dph != 1) chk("rready_gate", bmain_rready_dctl, 0);
        if (dph == 1) begin
            chk("rready_pass", bmain_rready_dctl, m_rready[dm]);
            chk("r_pass", {m_r[dm].valid, m_r[dm].last, m_r[dm].data},
                {dctl_rvalid, dctl_rlast, dctl_rdata});
        end
        if (dph == 2) begin
            chk("wready_pass", m_wready[dm], dctl_wready);
            chk("wvalid_pass", bmain_wvalid_dctl, m_w[dm].valid);
        end
        if (bmain_cvalid_dctl && last_end >= 0) begin
            chk("bubble", cyc - last_end, 2);
            last_end = -1;
        end
        // controller side
        if (dph == 0 && bmain_cvalid_dctl && dctl_cready) begin
            if (kc < ocnt) begin
                t = ord[kc];
                chk("cmd_owner", m_cready[t.m], 1);
                chk("cmd_addr", {bmain_cmd, bmain_addr}, {t.rd, t.addr});
                kc++;
                dph = t.rd ? 1 : 2;
                dw = 0; dr = 0;
            end else begin
                chk("extra_cmd", bmain_cvalid_dctl & dctl_cready, 0);
            end
        end else if (dph == 2 && bmain_wvalid_dctl && dctl_wready) begin
            t = ord[kc-1];
            chk("wbeat", {bmain_wlast, bmain_wmask, bmain_wdata},
                {dw == int'(t.lp), t.mask, t.base + 32'(dw)});
            dw++;
            if (dw == int'(t.lp) + 1) begin dph = 0; last_end = cyc; end
        end else if (dph == 1 && dctl_rvalid && bmain_rready_dctl) begin
            dr++; rbeats++;
            if (dr == BL) begin dph = 0; last_end = cyc; end
        end
        // master side
        for (int i = 0; i < 2; i++) begin
            if (mhead[i] < mcnt[i]) t = mtx[i][mhead[i]];
            else t = '0;
            if (m_c[i].valid && m_cready[i]) cmd_done[i] = 1'b1;
            if (m_w[i].valid && m_wready[i]) begin
                widx[i]++;
                if (m_w[i].last) begin
                    mhead[i]++; cmd_done[i] = 1'b0; widx[i] = 0;
                end
            end
            if (m_r[i].valid && m_rready[i]) begin
                if (mhead[i] < mcnt[i] && t.rd && cmd_done[i]) begin
                    chk("m_rdata", {m_r[i].last, m_r[i].data},
                        {ridx[i] == BL - 1, rpat(t.addr, ridx[i])});
                    ridx[i]++;
                    if (ridx[i] == BL) begin
                        mhead[i]++; cmd_done[i] = 1'b0; ridx[i] = 0;
                    end
                end else begin
                    chk("spurious_r", m_r[i].valid & m_rready[i], 0);
                end
            end
        end
    endtask

    task automatic run(input int abort_rb);
        int a0, a1, budget;
        bit p;
        ocnt = 0; kc = 0; dph = 0; dw = 0; dr = 0;
        last_end = -1; rbeats = 0; bp_cnt = 0;
        a0 = mhead[0]; a1 = mhead[1];
        while (a0 < mcnt[0] || a1 < mcnt[1]) begin
            if (a0 < mcnt[0] && a1 < mcnt[1]) p = mptr;
            else p = (a0 < mcnt[0]) ? 1'b0 : 1'b1;
            if (p) begin ord[ocnt] = mtx[1][a1]; a1++; end
            else begin ord[ocnt] = mtx[0][a0]; a0++; end
            ocnt++;
            mptr = ~p;
        end
        budget = 0;
        while ((kc < ocnt || dph != 0) && budget < LIM) begin
            @(negedge clk_core);
            drive();
            #1;
            observe();
            cyc++; budget++;
            if (abort_rb > 0 && rbeats >= abort_rb) break;
        end
        chk("timeout", 64'(budget < LIM), 1);
    endtask

    task automatic post();
        @(negedge clk_core);
        drive_idle();
        #1;
        cyc++;
        chk("arb_error", arb_error, err_exp);
        chk("idle_outs", {bmain_cvalid_dctl, bmain_wvalid_dctl,
                          bmain_rready_dctl, m_cready, m_wready}, 0);
        clear_masters();
    endtask

    task automatic do_reset();
        @(negedge clk_core);
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        reset_n = 1'b1;
        m_w[0].valid = 1'b1; m_w[1].valid = 1'b1;
        m_rready = 2'b11;
        dctl_cready = 1'b1; dctl_wready = 1'b1; dctl_rvalid = 1'b1;
        #1;
        chk("reset_outs", {bmain_cvalid_dctl, bmain_wvalid_dctl,
                           bmain_rready_dctl, m_cready, m_wready,
                           m_r[0].valid, m_r[1].valid}, 0);
        chk("reset_err", arb_error, 0);
        clear_masters();
        mptr = 1'b0; err_exp = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk_core);
        reset_n = 1'b0;
        m_c = '0;
        m_c[1].valid = 1'b1; m_c[1].cmd = 1'b1; m_c[1].addr = 26'h40;
        m_w[0].valid = 1'b1; m_w[1].valid = 1'b1;
        m_rready = 2'b11;
        dctl_cready = 1'b1; dctl_wready = 1'b1; dctl_rvalid = 1'b1;
        @(negedge clk_core);
        reset_n = 1'b1;
        #1;
        chk("midreset_outs", {bmain_cvalid_dctl, bmain_wvalid_dctl,
                              bmain_rready_dctl, m_cready, m_wready,
                              m_r[0].valid, m_r[1].valid, arb_error}, 0);
        clear_masters();
        mptr = 1'b0; err_exp = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        mptr = 1'b0; err_exp = 1'b0; bp_mode = 1'b0;
        reset_n = 1'b0;
        drive_idle();
        clear_masters();
        do_reset();
        // single read by m0
        add(0, 1, 26'h100, 0, 0, BL - 1);
        run(0); post();
        // pointer now favours m1
        add(0, 1, 26'h200, 0, 0, BL - 1);
        add(1, 1, 26'h300, 0, 0, BL - 1);
        run(0); post();
        // contention straight after reset: m0 first
        do_reset();
        add(0, 1, 26'h110, 0, 0, BL - 1);
        add(1, 1, 26'h120, 0, 0, BL - 1);
        run(0); post();
        // m1 write burst
        add(1, 0, 26'h80, 32'hA0, 4'hF, BL - 1);
        run(0); post();
        // read backpressure
        bp_mode = 1'b1;
        add(0, 1, 26'h140, 0, 0, BL - 1);
        run(0); post();
        bp_mode = 1'b0;
        // early last, then a legal burst, then a late last
        add(1, 0, 26'h10, 32'hB0, 4'h3, 1);
        run(0); post();
        add(0, 1, 26'h20, 0, 0, BL - 1);
        run(0); post();
        add(0, 0, 26'h30, 32'hC0, 4'hC, 5);
        run(0); post();
        // reset in the middle of a read burst
        do_reset();
        add(0, 1, 26'h180, 0, 0, BL - 1);
        run(2);
        mid_reset();
        add(1, 1, 26'h40, 0, 0, BL - 1);
        run(0); post();
        // random mix of legal bursts
        for (int k = 0; k < 24; k++) begin
            add(1'($urandom % 2), 1'($urandom % 2), 26'($urandom),
                $urandom, 4'($urandom), BL - 1);
        end
        run(0); post();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bmain_arb.md
Name:
bmain_arb

Overview:
- Two-master arbiter for the main memory bus, directly upstream of the DRAM controller.
- Master 0 is the icache refill path; master 1 is the dcache refill/writeback path.
- Grants one whole burst at a time: command beat, then the write-data or read-data beats.
- Multiplexes the granted master onto the controller's command/write/read channels and routes read data back to the owner only.

Parameters:
- BURST_LEN, default 4: data beats per burst; must match the controller's 16-byte line.

Ports:
- clk_core  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- m_c  in  bmain_c_t[1:0]  per-master command {valid, cmd (1=read, 0=write), addr[27:2]}
- m_cready  out  [1:0]  per-master command accept
- m_w  in  bmain_w_t[1:0]  per-master write data {valid, last, data[31:0], mask[3:0]}
- m_wready  out  [1:0]  per-master write accept
- m_r  out  bmain_r_t[1:0]  per-master read data {valid, last, data[31:0]}
- m_rready  in  [1:0]  per-master read accept
- bmain_cvalid_dctl  out  1  command valid to controller
- dctl_cready  in  1  controller command ready
- bmain_cmd  out  1  1=read, 0=write
- bmain_addr  out  [27:2]  word address
- bmain_wvalid_dctl  out  1  write data valid
- dctl_wready  in  1  controller write ready
- bmain_wlast  out  1  last write beat
- bmain_wdata  out  32  write data
- bmain_wmask  out  4  byte enables
- dctl_rvalid  in  1  read data valid
- bmain_rready_dctl  out  1  read ready
- dctl_rlast  in  1  last read beat
- dctl_rdata  in  32  read data
- arb_error  out  1  sticky protocol error

Behaviour:
- Beat = valid & ready on any channel.
- States: IDLE, CMD, WDATA, RDATA. The owner register (1 bit) and the priority pointer (1 bit) are both registered.
- IDLE:
  - All downstream valid/ready outputs are 0.
  - If any m_c[i].valid: owner <= the requesting master; if both request, owner <= the pointer master. Go to CMD.
  - Adds one bubble cycle.
- CMD:
  - bmain_cvalid_dctl = m_c[owner].valid; cmd/addr are taken from the owner.
  - m_cready[owner] = dctl_cready.
  - On a command beat: go to RDATA if cmd=1, WDATA if cmd=0. Beat counter <= 0.
  - If the owner drops valid before the beat: stay in CMD (no re-arbitration).
- WDATA:
  - m_w[owner] is forwarded downstream; m_wready[owner] = dctl_wready.
  - Counter increments on each beat.
  - On a beat with wlast: go to IDLE and set pointer <= ~owner.
- RDATA:
  - m_r[owner] = {dctl_rvalid, dctl_rlast, dctl_rdata}; bmain_rready_dctl = m_rready[owner].
  - Counter increments on each beat.
  - On a beat with rlast: go to IDLE and set pointer <= ~owner.
- Non-owner and IDLE outputs: the non-owner always sees cready=0, wready=0, r.valid=0. r.data may be driven to both masters; only valid is gated.
- Write data before grant: write data offered before the command beat is not accepted (wready=0 outside WDATA).
- Protocol check:
  - arb_error is set if a last-flagged beat occurs when counter != BURST_LEN-1.
  - arb_error is also set if a non-last beat occurs when counter == BURST_LEN-1.
  - Once set, arb_error holds until reset. Transfers continue, and the state still ends only on the last flag.
- Reset: state=IDLE, owner=0, pointer=0, counter=0, arb_error=0. All valid/ready outputs are 0 in the cycle after reset, including mid-burst.
- Counter width is $clog2(BURST_LEN) bits; it wraps with no saturation.

Decomposition:
- Package bmain_pkg: bmain_c_t, bmain_w_t, bmain_r_t packed structs; BMAIN_BURST_LEN=4; state enum.
- No sub-module; the round-robin pick is a single always_comb in the top.

Test Plan:
- Single read: m0 requests read at addr 0x100 (word), controller returns 4 beats -> m0 gets 4 r.valid beats, the last with last=1; m1 sees r.valid=0 throughout; ends in IDLE, pointer=1.
- Contention: m0 and m1 request in the same cycle after reset -> m0 is granted first; after its rlast, m1 is granted, with exactly one IDLE bubble in between.
- Write burst: m1 writes 4 words 0xA0..0xA3 with mask 0xF -> downstream sees the 4 beats in order with wlast on beat 3; m1 wready mirrors dctl_wready; m0 wready stays 0.
- Backpressure: m0 holds m_rready=0 for 3 cycles mid-burst -> bmain_rready_dctl=0 over those cycles; no beats are lost or duplicated; the data order is preserved.
- Protocol error: m1 asserts wlast on beat 1 -> arb_error=1 the next cycle; state returns to IDLE; arb_error stays 1 through a following legal burst.
- Reset mid-burst: reset_n=0 during RDATA beat 2 -> the next cycle all valids/readies are 0, state is IDLE; a new m1 request is then granted as owner 1 after the pointer resets.
